// File: rtl/axis_sink_pkg.sv
// Shared types and helpers for the AXI-Stream frame sink.
//   bp_mode_e  : tready backpressure mode encoding (matches cfg_bp_mode)
//   state_e    : capture FSM states
//   LFSR_TAPS  : Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   popcount   : set-bit count of a keep vector, zero-extended to POPCNT_W
//   lfsr_step  : one Galois LFSR advance
package axis_sink_pkg;

  localparam int unsigned POPCNT_W  = 128;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    BP_ALWAYS   = 2'd0,
    BP_PERIODIC = 2'd1,
    BP_LFSR     = 2'd2,
    BP_HOLD     = 2'd3
  } bp_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Number of set bits; result fits 8 bits for up to 128 byte lanes.
  function automatic logic [7:0] popcount(input logic [POPCNT_W-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < int'(POPCNT_W); i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/axis_bp_gen.sv
// Backpressure generator: produces the registered tready for the sink.
//   m_aclk, m_areset : clock, async active-high reset
//   en               : sink will be in CAPTURE next cycle; generator state
//                      advances only while enabled, otherwise it is frozen
//   mode             : backpressure mode
//   period           : periodic mode, ready once every period+1 cycles
//   trdy             : registered tready
module axis_bp_gen
  import axis_sink_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       m_aclk,
  input  logic       m_areset,
  input  logic       en,
  input  bp_mode_e   mode,
  input  logic [7:0] period,
  output logic       trdy
);

  logic [15:0] lfsr;
  logic [7:0]  cnt;
  logic        trdy_nxt_c;
  logic [15:0] lfsr_nxt_c;
  logic [7:0]  cnt_nxt_c;

  // Next ready value; the LFSR and the period counter each advance only in
  // their own mode so a pattern restarted from reset is reproducible.
  always_comb begin
    trdy_nxt_c = 1'b0;
    lfsr_nxt_c = lfsr;
    cnt_nxt_c  = cnt;
    if (en) begin
      unique case (mode)
        BP_ALWAYS:   trdy_nxt_c = 1'b1;
        BP_PERIODIC: begin
          trdy_nxt_c = (cnt == 8'd0);
          // >= also recovers when period shrinks below the running count
          cnt_nxt_c  = (cnt >= period) ? 8'd0 : cnt + 8'd1;
        end
        BP_LFSR: begin
          trdy_nxt_c = lfsr[0];
          lfsr_nxt_c = lfsr_step(lfsr);
        end
        BP_HOLD:     trdy_nxt_c = 1'b0;
        default:     trdy_nxt_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge m_aclk or posedge m_areset) begin
    if (m_areset) begin
      trdy <= 1'b0;
      lfsr <= LFSR_SEED;
      cnt  <= 8'd0;
    end else begin
      trdy <= trdy_nxt_c;
      lfsr <= lfsr_nxt_c;
      cnt  <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/axis_frame_sink.sv
// AXI-Stream frame sink: captures one armed frame into a buffer, counting
// stored beats and bytes, with configurable tready backpressure.
//   m_aclk, m_areset      : clock, async active-high reset
//   s_axis_*              : stream input; s_axis_trdy is registered
//   cfg_bp_mode/period    : backpressure selection
//   cfg_arm               : pulse to capture the next frame
//   buf_rd_addr/data/keep : synchronous buffer read port, 1-cycle latency
//   busy                  : in CAPTURE
//   frame_done            : one-cycle pulse per completed frame
//   frame_beats/len_bytes : stored beats/bytes of the last frame
//   frame_overflow        : last frame exceeded DEPTH beats
//   frame_count           : completed frames, wrapping
module axis_frame_sink
  import axis_sink_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH      = 2048,
  parameter bit          AUTO_REARM = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                                   m_aclk,
  input  logic                                   m_areset,
  input  logic [DATA_WIDTH-1:0]                  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                  s_axis_tkeep,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_trdy,
  input  logic [1:0]                             cfg_bp_mode,
  input  logic [7:0]                             cfg_bp_period,
  input  logic                                   cfg_arm,
  input  logic [$clog2(DEPTH)-1:0]               buf_rd_addr,
  output logic [DATA_WIDTH-1:0]                  buf_rd_data,
  output logic [KEEP_WIDTH-1:0]                  buf_rd_keep,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic [$clog2(DEPTH):0]                 frame_beats,
  output logic [$clog2(DEPTH*KEEP_WIDTH):0]      frame_len_bytes,
  output logic                                   frame_overflow,
  output logic [15:0]                            frame_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH * KEEP_WIDTH) + 1;
  localparam int unsigned MW = KEEP_WIDTH + DATA_WIDTH;

  state_e          state;
  state_e          state_nxt;
  logic [BW-1:0]   wr_ptr;
  logic [LW-1:0]   byte_cnt;
  logic            ovf;
  logic [MW-1:0]   mem [DEPTH];
  logic [MW-1:0]   rd_q;

  logic            accept_c;
  logic            start_c;
  logic            finish_c;
  logic            room_c;
  logic            mem_we_c;
  logic [LW-1:0]   byte_add_c;
  logic [BW-1:0]   ptr_nxt_c;
  logic [LW-1:0]   bytes_nxt_c;
  logic            ovf_nxt_c;

  // Next state plus running frame counters
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    start_c     = 1'b0;
    finish_c    = 1'b0;
    room_c      = 1'b0;
    mem_we_c    = 1'b0;
    byte_add_c  = '0;
    ptr_nxt_c   = wr_ptr;
    bytes_nxt_c = byte_cnt;
    ovf_nxt_c   = ovf;

    unique case (state)
      IDLE: begin
        if (cfg_arm) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        accept_c = s_axis_tvalid & s_axis_trdy;
        if (accept_c && s_axis_tlast) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = (AUTO_REARM || cfg_arm) ? CAPTURE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    start_c    = (state_nxt == CAPTURE) && (state != CAPTURE);
    finish_c   = accept_c && s_axis_tlast;
    room_c     = (wr_ptr < BW'(DEPTH));
    mem_we_c   = accept_c && room_c;
    byte_add_c = LW'(popcount(POPCNT_W'(s_axis_tkeep)));

    if (start_c) begin
      ptr_nxt_c   = '0;
      bytes_nxt_c = '0;
      ovf_nxt_c   = 1'b0;
    end else if (accept_c) begin
      if (room_c) begin
        ptr_nxt_c   = wr_ptr + BW'(1);
        bytes_nxt_c = byte_cnt + byte_add_c;
      end else begin
        // Full buffer: drain the rest of the frame without storing it
        ovf_nxt_c = 1'b1;
      end
    end
  end

  // State, status and result registers; results latch on the DONE entry edge
  always_ff @(posedge m_aclk or posedge m_areset) begin
    if (m_areset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      wr_ptr          <= '0;
      byte_cnt        <= '0;
      ovf             <= 1'b0;
      frame_beats     <= '0;
      frame_len_bytes <= '0;
      frame_overflow  <= 1'b0;
      frame_count     <= 16'd0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt == CAPTURE);
      frame_done <= (state_nxt == DONE);
      wr_ptr     <= ptr_nxt_c;
      byte_cnt   <= bytes_nxt_c;
      ovf        <= ovf_nxt_c;
      if (finish_c) begin
        frame_beats     <= ptr_nxt_c;
        frame_len_bytes <= bytes_nxt_c;
        frame_overflow  <= ovf_nxt_c;
        frame_count     <= frame_count + 16'd1;
      end
    end
  end

  axis_bp_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_bp_gen (
    .m_aclk   (m_aclk),
    .m_areset (m_areset),
    .en       (state_nxt == CAPTURE),
    .mode     (bp_mode_e'(cfg_bp_mode)),
    .period   (cfg_bp_period),
    .trdy     (s_axis_trdy)
  );

  // Buffer storage; no reset so it maps onto RAM
  always_ff @(posedge m_aclk) begin
    if (mem_we_c) mem[wr_ptr[AW-1:0]] <= {s_axis_tkeep, s_axis_tdata};
  end

  // Read-first registered read port
  always_ff @(posedge m_aclk or posedge m_areset) begin
    if (m_areset) rd_q <= '0;
    else          rd_q <= mem[buf_rd_addr];
  end

  assign buf_rd_data = rd_q[DATA_WIDTH-1:0];
  assign buf_rd_keep = rd_q[MW-1:DATA_WIDTH];

endmodule

// File: tb/tb_axis_frame_sink.sv
module tb_axis_frame_sink;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          MDEPTH = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: 32-bit data, 128-beat buffer, manual arming
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, trdy, arm;
  logic [1:0]  mode;
  logic [7:0]  period;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_keep;
  logic        busy, frame_done, frame_overflow;
  logic [7:0]  frame_beats;
  logic [9:0]  frame_len_bytes;
  logic [15:0] frame_count;

  axis_frame_sink #(
    .DATA_WIDTH (32), .KEEP_WIDTH (4), .DEPTH (MDEPTH), .AUTO_REARM (1'b0), .LFSR_SEED (SEED)
  ) u_main (
    .m_aclk (clk), .m_areset (rst),
    .s_axis_tdata (tdata), .s_axis_tkeep (tkeep), .s_axis_tvalid (tvalid),
    .s_axis_tlast (tlast), .s_axis_trdy (trdy),
    .cfg_bp_mode (mode), .cfg_bp_period (period), .cfg_arm (arm),
    .buf_rd_addr (rd_addr), .buf_rd_data (rd_data), .buf_rd_keep (rd_keep),
    .busy (busy), .frame_done (frame_done), .frame_beats (frame_beats),
    .frame_len_bytes (frame_len_bytes), .frame_overflow (frame_overflow),
    .frame_count (frame_count)
  );

  // Small instance: 8-bit data, 8-beat buffer, automatic re-arm
  logic [7:0]  s_tdata;
  logic [0:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_trdy, s_arm;
  logic [1:0]  s_mode;
  logic [7:0]  s_period;
  logic [2:0]  s_rd_addr;
  logic [7:0]  s_rd_data;
  logic [0:0]  s_rd_keep;
  logic        s_busy, s_done, s_ovf;
  logic [3:0]  s_beats;
  logic [3:0]  s_bytes;
  logic [15:0] s_count;

  axis_frame_sink #(
    .DATA_WIDTH (8), .KEEP_WIDTH (1), .DEPTH (8), .AUTO_REARM (1'b1), .LFSR_SEED (SEED)
  ) u_small (
    .m_aclk (clk), .m_areset (rst),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tvalid (s_tvalid),
    .s_axis_tlast (s_tlast), .s_axis_trdy (s_trdy),
    .cfg_bp_mode (s_mode), .cfg_bp_period (s_period), .cfg_arm (s_arm),
    .buf_rd_addr (s_rd_addr), .buf_rd_data (s_rd_data), .buf_rd_keep (s_rd_keep),
    .busy (s_busy), .frame_done (s_done), .frame_beats (s_beats),
    .frame_len_bytes (s_bytes), .frame_overflow (s_ovf), .frame_count (s_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [35:0] exp_buf[$];
  int          exp_count;
  logic [15:0] m_lfsr;
  int          m_pcyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Expected tready for one CAPTURE cycle under the currently selected mode
  function automatic logic exp_trdy_step();
    logic e;
    case (mode)
      2'd0: e = 1'b1;
      2'd1: begin
        e = ((m_pcyc % (int'(period) + 1)) == 0);
        m_pcyc++;
      end
      2'd2: begin
        e = m_lfsr[0];
        m_lfsr = lfsr_adv(m_lfsr);
      end
      default: e = 1'b0;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    exp_count = 0;
    m_lfsr    = SEED;
    m_pcyc    = 0;
  endtask

  // keep_sel: 0 all lanes, 1 random lanes, 2 one lane with data = beat+1
  task automatic send_frame(input int n, input int vpct, input int keep_sel,
                            input int last_keep, input bit do_arm);
    int   idx;
    int   budget;
    int   stored;
    int   exp_bytes;
    logic acc;
    exp_buf.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      logic [3:0]  k;
      d = (keep_sel == 2) ? 32'(i + 1) : $urandom;
      k = (keep_sel == 0) ? 4'hF : (keep_sel == 2) ? 4'h1 : 4'($urandom_range(0, 15));
      if (i == n - 1 && last_keep >= 0) k = 4'(last_keep);
      exp_buf.push_back({k, d});
    end
    if (do_arm) begin
      @(negedge clk); arm = 1'b1;
      @(negedge clk); arm = 1'b0;
    end
    idx = 0; budget = 0; tvalid = 1'b0;
    while (idx < n && budget < 5000) begin
      if (!tvalid) begin
        tvalid = ($urandom_range(0, 99) < 32'(vpct));
        {tkeep, tdata} = exp_buf[idx];
        tlast = (idx == n - 1);
      end
      check("capture_busy", 64'(busy), 64'(1));
      check("capture_trdy", 64'(trdy), 64'(exp_trdy_step()));
      acc = tvalid && trdy;
      @(negedge clk);
      budget++;
      if (acc) begin
        idx++;
        tvalid = 1'b0;
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
    check("frame_accept_budget", 64'(idx), 64'(n));
    stored = (n < MDEPTH) ? n : MDEPTH;
    exp_bytes = 0;
    for (int i = 0; i < stored; i++) exp_bytes += $countones(exp_buf[i][35:32]);
    exp_count++;
    check("frame_done", 64'(frame_done), 64'(1));
    check("done_busy", 64'(busy), 64'(0));
    check("done_trdy", 64'(trdy), 64'(0));
    check("frame_beats", 64'(frame_beats), 64'(stored));
    check("frame_len_bytes", 64'(frame_len_bytes), 64'(exp_bytes));
    check("frame_overflow", 64'(frame_overflow), 64'(n > MDEPTH));
    check("frame_count", 64'(frame_count), 64'(16'(exp_count)));
    @(negedge clk);
    check("done_pulse_end", 64'(frame_done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic check_buf(input int n);
    for (int a = 0; a < n; a++) begin
      rd_addr = 7'(a);
      @(negedge clk);
      check("buf_word", 64'({rd_keep, rd_data}), 64'(exp_buf[a]));
    end
  endtask

  initial begin
    int beat;
    int done_n;
    int budget;
    logic acc;

    rst = 1'b1;
    tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0; arm = 1'b0;
    mode = 2'd0; period = 8'd0; rd_addr = '0;
    s_tdata = '0; s_tkeep = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_arm = 1'b0;
    s_mode = 2'd0; s_period = 8'd0; s_rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_trdy", 64'(trdy), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));
    check("rst_ovf", 64'(frame_overflow), 64'(0));
    check("rst_beats", 64'(frame_beats), 64'(0));
    check("rst_bytes", 64'(frame_len_bytes), 64'(0));
    check("rst_count", 64'(frame_count), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_rd_keep", 64'(rd_keep), 64'(0));
    check("rst_small_count", 64'(s_count), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Always-ready, 4 single-byte beats 01..04
    mode = 2'd0;
    send_frame(4, 100, 2, -1, 1'b1);
    check_buf(4);

    // Periodic ready 1-in-3, last beat with two lanes: 4+4+2 bytes
    mode = 2'd1; period = 8'd2;
    send_frame(3, 100, 0, 3, 1'b1);
    check("periodic_bytes", 64'(frame_len_bytes), 64'(10));
    check_buf(3);

    // Random keep (including empty beats) and random tvalid
    mode = 2'd0;
    send_frame(20, 60, 1, -1, 1'b1);
    check_buf(20);

    // Overflow: 130 beats into 128 entries, then back to idle
    send_frame(130, 100, 1, -1, 1'b1);
    check_buf(MDEPTH);
    repeat (2) begin
      @(negedge clk);
      check("ovf_idle_busy", 64'(busy), 64'(0));
      check("ovf_idle_trdy", 64'(trdy), 64'(0));
    end

    // Hold mode: never ready, arm ignored while capturing; release by mode change
    mode = 2'd3;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    tvalid = 1'b1; tdata = 32'h1234_5678; tkeep = 4'hF; tlast = 1'b1;
    for (int c = 0; c < 30; c++) begin
      arm = (c == 10);
      @(negedge clk);
      check("hold_trdy", 64'(trdy), 64'(0));
      check("hold_done", 64'(frame_done), 64'(0));
      check("hold_busy", 64'(busy), 64'(1));
    end
    arm = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    mode = 2'd0;
    @(negedge clk);
    send_frame(1, 100, 0, -1, 1'b0);
    check_buf(1);

    // Asynchronous reset in the middle of a frame
    mode = 2'd0;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
    tvalid = 1'b1; tdata = 32'hDEAD_0000; tkeep = 4'hF; tlast = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_trdy", 64'(trdy), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    tvalid = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_trdy", 64'(trdy), 64'(0));
    check("post_rst_count", 64'(frame_count), 64'(0));
    check("post_rst_beats", 64'(frame_beats), 64'(0));
    send_frame(2, 100, 0, -1, 1'b1);
    check_buf(2);

    // LFSR backpressure from the reset seed, random tvalid, 100 beats
    mode = 2'd2;
    send_frame(100, 50, 1, -1, 1'b1);
    check_buf(100);

    // Auto re-arm: frame of 3 then a frame of 10 with only one arm pulse
    @(negedge clk); s_arm = 1'b1;
    @(negedge clk); s_arm = 1'b0;
    beat = 0; done_n = 0; budget = 0;
    s_tvalid = 1'b1;
    while (beat < 13 && budget < 200) begin
      s_tdata = 8'(beat + 16);
      s_tlast = (beat == 2) || (beat == 12);
      acc = s_trdy;
      @(negedge clk);
      budget++;
      if (s_done) begin
        done_n++;
        if (done_n == 1) begin
          check("rearm_f1_beats", 64'(s_beats), 64'(3));
          check("rearm_f1_count", 64'(s_count), 64'(1));
          check("rearm_done_trdy", 64'(s_trdy), 64'(0));
        end
      end
      if (acc) beat++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("rearm_done_pulses", 64'(done_n), 64'(2));
    check("rearm_f2_beats", 64'(s_beats), 64'(8));
    check("rearm_f2_bytes", 64'(s_bytes), 64'(8));
    check("rearm_f2_ovf", 64'(s_ovf), 64'(1));
    check("rearm_f2_count", 64'(s_count), 64'(2));
    @(negedge clk);
    check("rearm_busy_again", 64'(s_busy), 64'(1));
    for (int a = 0; a < 8; a++) begin
      s_rd_addr = 3'(a);
      @(negedge clk);
      check("rearm_buf", 64'({s_rd_keep, s_rd_data}), 64'({1'b1, 8'(a + 19)}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
